// File: rtl/sensor_line_sync.sv
// Sensor line synchroniser: two-stage pixel pipeline, frame-start pulse, pass/regenerated HACT, line counter.
// Optional build macro SENSOR_LINE_SYNC_TEST_PATTERN_EN adds a test_pattern input driving a counter ramp onto ipxd.
module sensor_line_sync #(
    parameter int DATA_WIDTH = 12,
    parameter int OUT_WIDTH  = 16,
    parameter int HLEN_WIDTH = 14,
    parameter int VLEN_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vact_in,
    input  logic                  hact_in,
    input  logic [DATA_WIDTH-1:0] pxd_in,
    input  logic [HLEN_WIDTH-1:0] hact_length,
    input  logic                  hact_regen,
    input  logic                  en_vacts,
`ifdef SENSOR_LINE_SYNC_TEST_PATTERN_EN
    input  logic                  test_pattern,
`endif
    output logic                  vacts,
    output logic                  ihact,
    output logic [OUT_WIDTH-1:0]  ipxd,
    output logic [VLEN_WIDTH-1:0] line_num,
    output logic                  overrun
);

    localparam int PAD = OUT_WIDTH - DATA_WIDTH;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic                  vact_s1_reg, hact_s1_reg;
    logic [DATA_WIDTH-1:0] pxd_s1_reg;
    logic                  vact_s2_reg, hact_s2_reg;

    state_t                state_reg, state_next;
    logic                  mode_reg, mode_next;
    logic [HLEN_WIDTH-1:0] cnt_reg, cnt_next;
    logic                  armed_reg, armed_next;
    logic                  vacts_reg, vacts_next;
    logic                  ihact_reg, ihact_next;
    logic [OUT_WIDTH-1:0]  ipxd_reg, ipxd_next;
    logic [VLEN_WIDTH-1:0] line_num_reg, line_num_next;
    logic                  overrun_reg, overrun_next;

    logic                  vact_rise, hact_rise, ihact_fall, overrun_set;
    logic [OUT_WIDTH-1:0]  pxd_aligned;

    // MSB-align the stage-1 pixel; PAD may be zero, hence per-bit generation.
    genvar gi;
    generate
        for (gi = 0; gi < OUT_WIDTH; gi++) begin : g_align
            if (gi < PAD) begin : g_pad
                assign pxd_aligned[gi] = 1'b0;
            end else begin : g_pix
                assign pxd_aligned[gi] = pxd_s1_reg[gi-PAD];
            end
        end
    endgenerate

`ifdef SENSOR_LINE_SYNC_TEST_PATTERN_EN
    logic [HLEN_WIDTH-1:0] pix_cnt_reg, pix_cnt_next, pix_idx;
`endif

    always_comb begin
        state_next    = state_reg;
        mode_next     = mode_reg;
        cnt_next      = cnt_reg;
        ihact_next    = 1'b0;
        overrun_set   = 1'b0;
        line_num_next = line_num_reg;

        vact_rise  = vact_s1_reg & ~vact_s2_reg;
        hact_rise  = hact_s1_reg & ~hact_s2_reg;
        vacts_next = vact_rise & (en_vacts | armed_reg);
        armed_next = en_vacts ? 1'b1 : (vacts_next ? 1'b0 : armed_reg);

        case (state_reg)
            IDLE: begin
                mode_next = hact_regen;
                if (hact_regen) begin
                    if (hact_rise) begin
                        state_next = ACTIVE;
                        cnt_next   = hact_length;
                        ihact_next = 1'b1;
                    end
                end else if (hact_s1_reg) begin
                    state_next = ACTIVE;
                    ihact_next = 1'b1;
                end
            end
            ACTIVE: begin
                if (mode_reg) begin
                    overrun_set = hact_rise;
                    if (cnt_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        cnt_next   = cnt_reg - HLEN_WIDTH'(1);
                        ihact_next = 1'b1;
                    end
                end else begin
                    ihact_next = hact_s1_reg;
                    if (!hact_s1_reg) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A line ending on the frame-start cycle is credited to the new frame.
        ihact_fall = ihact_reg & ~ihact_next;
        if (vacts_next) begin
            line_num_next = ihact_fall ? VLEN_WIDTH'(1) : '0;
        end else if (ihact_fall && (line_num_reg != '1)) begin
            line_num_next = line_num_reg + VLEN_WIDTH'(1);
        end

        overrun_next = overrun_set | (overrun_reg & ~vacts_next);

        ipxd_next = pxd_aligned;
`ifdef SENSOR_LINE_SYNC_TEST_PATTERN_EN
        pix_idx      = ihact_reg ? (pix_cnt_reg + HLEN_WIDTH'(1)) : '0;
        pix_cnt_next = ihact_next ? pix_idx : pix_cnt_reg;
        if (test_pattern) begin
            ipxd_next = OUT_WIDTH'(32'(pix_idx) + 32'(line_num_reg));
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vact_s1_reg  <= 1'b0;
            hact_s1_reg  <= 1'b0;
            pxd_s1_reg   <= '0;
            vact_s2_reg  <= 1'b0;
            hact_s2_reg  <= 1'b0;
            state_reg    <= IDLE;
            mode_reg     <= 1'b0;
            cnt_reg      <= '0;
            armed_reg    <= 1'b1;
            vacts_reg    <= 1'b0;
            ihact_reg    <= 1'b0;
            ipxd_reg     <= '0;
            line_num_reg <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            vact_s1_reg  <= vact_in;
            hact_s1_reg  <= hact_in;
            pxd_s1_reg   <= pxd_in;
            vact_s2_reg  <= vact_s1_reg;
            hact_s2_reg  <= hact_s1_reg;
            state_reg    <= state_next;
            mode_reg     <= mode_next;
            cnt_reg      <= cnt_next;
            armed_reg    <= armed_next;
            vacts_reg    <= vacts_next;
            ihact_reg    <= ihact_next;
            ipxd_reg     <= ipxd_next;
            line_num_reg <= line_num_next;
            overrun_reg  <= overrun_next;
        end
    end

`ifdef SENSOR_LINE_SYNC_TEST_PATTERN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_reg <= '0;
        end else begin
            pix_cnt_reg <= pix_cnt_next;
        end
    end
`endif

    assign vacts    = vacts_reg;
    assign ihact    = ihact_reg;
    assign ipxd     = ipxd_reg;
    assign line_num = line_num_reg;
    assign overrun  = overrun_reg;

endmodule

// File: tb/tb_sensor_line_sync.sv
// Bench for sensor_line_sync: cycle model of the pin-to-output rules checked every cycle, plus literal checks.
module tb_sensor_line_sync;

    localparam int DW = 12;
    localparam int OW = 16;
    localparam int HW = 14;
    localparam int VW = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          vact_in = 1'b0;
    logic          hact_in = 1'b0;
    logic [DW-1:0] pxd_in = '0;
    logic [HW-1:0] hact_length = '0;
    logic          hact_regen = 1'b0;
    logic          en_vacts = 1'b1;

    logic          vacts, ihact, overrun;
    logic [OW-1:0] ipxd;
    logic [VW-1:0] line_num;
    logic          vacts_b, ihact_b, overrun_b;
    logic [OW-1:0] ipxd_b;
    logic [3:0]    line_num_b;

    sensor_line_sync #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .HLEN_WIDTH(HW), .VLEN_WIDTH(VW)) dut (
        .clk(clk), .rst(rst), .vact_in(vact_in), .hact_in(hact_in), .pxd_in(pxd_in),
        .hact_length(hact_length), .hact_regen(hact_regen), .en_vacts(en_vacts),
        .vacts(vacts), .ihact(ihact), .ipxd(ipxd), .line_num(line_num), .overrun(overrun)
    );

    sensor_line_sync #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .HLEN_WIDTH(HW), .VLEN_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .vact_in(vact_in), .hact_in(hact_in), .pxd_in(pxd_in),
        .hact_length(hact_length), .hact_regen(hact_regen), .en_vacts(en_vacts),
        .vacts(vacts_b), .ihact(ihact_b), .ipxd(ipxd_b), .line_num(line_num_b), .overrun(overrun_b)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model state: what the pins looked like one edge ago, and line bookkeeping by absolute cycle.
    longint        m_cyc = 0;
    bit            m_v1 = 0, m_v1p = 0, m_h1 = 0, m_h1p = 0;
    logic [DW-1:0] m_p1 = '0;
    bit            m_armed = 1;
    int            m_kind = 0;      // 0 no line, 1 pass line, 2 regenerated line
    longint        m_end = 0;       // last cycle a regenerated line shows ihact
    bit            m_ih_prev = 0;
    bit            e_vacts = 0, e_ihact = 0, e_ovr = 0;
    int            e_lines = 0, e_lines4 = 0;
    logic [OW-1:0] e_ipxd = '0;

    always @(posedge clk) begin
        bit vrise, hrise, fall, ovr_set;
        m_cyc++;
        if (rst) begin
            m_v1 = 0; m_v1p = 0; m_h1 = 0; m_h1p = 0; m_p1 = '0;
            m_armed = 1; m_kind = 0; m_ih_prev = 0;
            e_vacts = 0; e_ihact = 0; e_ovr = 0; e_lines = 0; e_lines4 = 0; e_ipxd = '0;
        end else begin
            vrise   = m_v1 && !m_v1p;
            hrise   = m_h1 && !m_h1p;
            ovr_set = 0;
            e_vacts = vrise && (en_vacts || m_armed);
            if (en_vacts) m_armed = 1;
            else if (e_vacts) m_armed = 0;

            if (m_kind == 2) begin
                ovr_set = hrise;
                e_ihact = (m_cyc <= m_end);
                if (!e_ihact) m_kind = 0;
            end else if (m_kind == 1) begin
                e_ihact = m_h1;
                if (!m_h1) m_kind = 0;
            end else if (hact_regen) begin
                e_ihact = hrise;
                if (hrise) begin
                    m_kind = 2;
                    m_end  = m_cyc + longint'(hact_length);
                end
            end else begin
                e_ihact = m_h1;
                if (m_h1) m_kind = 1;
            end

            fall = m_ih_prev && !e_ihact;
            m_ih_prev = e_ihact;
            if (e_vacts) begin
                e_lines  = fall ? 1 : 0;
                e_lines4 = fall ? 1 : 0;
            end else if (fall) begin
                if (e_lines < (1 << VW) - 1) e_lines++;
                if (e_lines4 < 15) e_lines4++;
            end
            if (ovr_set) e_ovr = 1;
            else if (e_vacts) e_ovr = 0;
            e_ipxd = OW'(m_p1) << (OW - DW);

            m_v1p = m_v1; m_v1 = vact_in;
            m_h1p = m_h1; m_h1 = hact_in;
            m_p1  = pxd_in;
        end
    end

    int n_ihact = 0;
    int n_vacts = 0;

    always @(negedge clk) begin
        check("vacts", vacts, e_vacts);
        check("ihact", ihact, e_ihact);
        check("ipxd", ipxd, e_ipxd);
        check("line_num", line_num, e_lines);
        check("line_num_w4", line_num_b, e_lines4);
        check("overrun", overrun, e_ovr);
        if (ihact) n_ihact++;
        if (vacts) n_vacts++;
    end

    bit hold_pxd = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            if (!hold_pxd) pxd_in = DW'(pxd_in * 7 + 13);
        end
    endtask

    task automatic new_frame();
        vact_in = 0;
        step(2);
        vact_in = 1;
        step(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        step(3);
        check("rst_vacts", vacts, 0);
        check("rst_ihact", ihact, 0);
        check("rst_ipxd", ipxd, 0);
        check("rst_line_num", line_num, 0);
        check("rst_overrun", overrun, 0);
        rst = 0;
        step(2);

        n_vacts = 0;
        new_frame();
        check("first_frame_vacts", n_vacts, 1);

        // Pass mode: latency and MSB alignment
        hold_pxd = 1;
        pxd_in = 12'hABC;
        hact_in = 1;
        step(1);
        check("pass_ihact_after1", ihact, 0);
        step(1);
        check("pass_ihact_after2", ihact, 1);
        check("pass_ipxd_abc0", ipxd, 16'hABC0);
        hold_pxd = 0;
        step(3);
        hact_in = 0;
        step(4);
        check("pass_line_count", line_num, 1);

        // Regenerated line of 100 cycles; length change mid-line must not matter
        new_frame();
        check("regen_ln_before", line_num, 0);
        hact_regen = 1;
        hact_length = 99;
        n_ihact = 0;
        hact_in = 1;
        step(10);
        hact_in = 0;
        hact_length = 5;
        step(110);
        check("regen_len100", n_ihact, 100);
        check("regen_ln_after", line_num, 1);
        check("regen_no_overrun", overrun, 0);

        // Zero length gives a single-cycle line
        hact_length = 0;
        n_ihact = 0;
        hact_in = 1;
        step(3);
        hact_in = 0;
        step(5);
        check("regen_len1", n_ihact, 1);
        check("regen_len1_ln", line_num, 2);

        // Second HACT rise inside an active line
        new_frame();
        hact_length = 99;
        n_ihact = 0;
        hact_in = 1;
        step(10);
        hact_in = 0;
        step(40);
        hact_in = 1;
        step(10);
        hact_in = 0;
        step(70);
        check("overrun_len", n_ihact, 100);
        check("overrun_set", overrun, 1);
        check("overrun_ln", line_num, 1);
        step(20);
        check("overrun_sticky", overrun, 1);
        new_frame();
        check("overrun_cleared", overrun, 0);

        // Triggered (one-shot) frame starts, then free-running again
        en_vacts = 0;
        n_vacts = 0;
        repeat (3) new_frame();
        check("oneshot_count", n_vacts, 1);
        en_vacts = 1;
        n_vacts = 0;
        repeat (3) new_frame();
        check("freerun_count", n_vacts, 3);

        // 300 pass-mode lines, saturation of the 4-bit counter, clear on vacts
        hact_regen = 0;
        new_frame();
        repeat (300) begin
            hact_in = 1;
            step(2);
            hact_in = 0;
            step(2);
        end
        step(3);
        check("ln300", line_num, 300);
        check("ln_w4_sat", line_num_b, 15);
        vact_in = 0;
        step(2);
        vact_in = 1;
        step(1);
        check("ln300_hold", line_num, 300);
        step(1);
        check("vacts_pulse", vacts, 1);
        check("ln_clear", line_num, 0);
        step(2);

        // Frame start and line start on the same cycle
        hact_regen = 1;
        hact_length = 3;
        hact_in = 1;
        step(2);
        hact_in = 0;
        step(8);
        check("coinc_pre_ln", line_num, 1);
        vact_in = 0;
        step(2);
        vact_in = 1;
        hact_in = 1;
        step(2);
        hact_in = 0;
        step(10);
        check("coinc_ln", line_num, 1);

        // Reset in the middle of a regenerated line
        hact_length = 99;
        hact_in = 1;
        step(10);
        hact_in = 0;
        step(10);
        rst = 1;
        step(1);
        check("midrst_ihact", ihact, 0);
        check("midrst_ipxd", ipxd, 0);
        check("midrst_ln", line_num, 0);
        check("midrst_vacts", vacts, 0);
        check("midrst_overrun", overrun, 0);
        rst = 0;
        n_ihact = 0;
        step(120);
        check("midrst_no_line", n_ihact, 0);
        check("midrst_not_counted", line_num, 0);
        hact_in = 1;
        step(3);
        hact_in = 0;
        step(110);
        check("midrst_fresh_len", n_ihact, 100);
        check("midrst_fresh_ln", line_num, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
